// File: rtl/i2s_pkg.sv
// Shared definitions for the I2S transmitter/receiver family: default frame
// geometry, the counter-width helper and the word-clock channel encoding.
package i2s_pkg;

    // Default sample width and bit clocks per half-frame
    localparam int DEF_BITSIZE = 24;
    localparam int DEF_SLOT    = 24;

    // Word-clock level for each channel; the receiver decodes with the same values
    typedef enum logic {
        LEFT  = 1'b0,
        RIGHT = 1'b1
    } chan_e;

    // Width of a counter that spans one full stereo frame (2*slot bit clocks)
    function automatic int cnt_width(input int slot);
        return $clog2(2 * slot);
    endfunction

endpackage

// File: rtl/i2s_frame_gen.sv
// Frame timing for an I2S clock master. A free-running counter walks through
// one stereo frame of 2*SLOT bit clocks. The module produces the registered
// word clock and frame_start pulse, and it decodes which channel and bit
// position belong to the serial-data bit registered on the coming edge.
module i2s_frame_gen
    import i2s_pkg::*;
#(
    parameter int  SLOT = DEF_SLOT,
    localparam int CW   = cnt_width(SLOT)
) (
    input  logic          sclk,
    input  logic          rst,
    output logic          lrclk,
    output logic          frame_start,
    output logic          load_edge,
    output chan_e         next_chan,
    output logic [CW-1:0] next_bit
);

    localparam logic [CW-1:0] SLOT_C = CW'(SLOT);
    localparam logic [CW-1:0] LAST_C = CW'(2 * SLOT - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    chan_e         lr_q, lr_d;
    logic          fs_q, fs_d;

    // Next counter value, and the word clock and frame pulse that belong with it
    always_comb begin
        cnt_d = (cnt_q == LAST_C) ? '0 : cnt_q + CW'(1);
        lr_d  = (cnt_d < SLOT_C) ? LEFT : RIGHT;
        fs_d  = (cnt_q == '0);
    end

    // Frame counter, word clock and frame-start pulse registers
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            lr_q  <= LEFT;
            fs_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            lr_q  <= lr_d;
            fs_q  <= fs_d;
        end
    end

    // The bit shown during counter value c sits at position (c-1) mod 2*SLOT.
    // That position equals the current counter value, so it is decoded
    // directly from cnt_q, one edge ahead of the register that holds the bit.
    always_comb begin
        load_edge = (cnt_q == '0);
        if (cnt_q < SLOT_C) begin
            next_chan = LEFT;
            next_bit  = cnt_q;
        end else begin
            next_chan = RIGHT;
            next_bit  = cnt_q - SLOT_C;
        end
    end

    assign lrclk       = lr_q;
    assign frame_start = fs_q;

endmodule

// File: rtl/i2s_tx.sv
// I2S master transmitter. Stereo pairs are accepted over valid/ready into a
// holding buffer. At the start of each frame the pair moves into the shift
// pair, which is then serialised MSB first with the usual one-bit delay after
// every word-clock edge. A frame that starts with an empty holding buffer is
// sent as zeros and flagged with an underrun pulse.
module i2s_tx
    import i2s_pkg::*;
#(
    parameter int BITSIZE = DEF_BITSIZE,
    parameter int SLOT    = DEF_SLOT
) (
    input  logic               sclk,
    input  logic               rst,
    input  logic [BITSIZE-1:0] left_in,
    input  logic [BITSIZE-1:0] right_in,
    input  logic               sample_valid,
    output logic               sample_ready,
    output logic               lrclk,
    output logic               sdata,
    output logic               frame_start,
    output logic               underrun
);

    localparam int            CW     = cnt_width(SLOT);
    localparam logic [CW-1:0] BITS_C = CW'(BITSIZE);

    logic          load_edge;
    chan_e         next_chan;
    logic [CW-1:0] next_bit;

    logic [BITSIZE-1:0] hold_l_q, hold_l_d;
    logic [BITSIZE-1:0] hold_r_q, hold_r_d;
    logic               hold_full_q, hold_full_d;
    logic [BITSIZE-1:0] shl_q, shl_d;
    logic [BITSIZE-1:0] shr_q, shr_d;
    logic               sdata_q, sdata_d;
    logic               underrun_q, underrun_d;
    logic               accept;
    logic [BITSIZE-1:0] out_word;
    logic [BITSIZE-1:0] out_shifted;

    i2s_frame_gen #(
        .SLOT(SLOT)
    ) u_frame_gen (
        .sclk        (sclk),
        .rst         (rst),
        .lrclk       (lrclk),
        .frame_start (frame_start),
        .load_edge   (load_edge),
        .next_chan   (next_chan),
        .next_bit    (next_bit)
    );

    // Handshake into the holding pair, and the frame-start transfer into the
    // shift pair. An accept needs an empty holding buffer, so it never
    // collides with a transfer out of a full one. A pair accepted on the
    // transfer edge itself waits for the following frame.
    always_comb begin
        accept      = sample_valid && !hold_full_q;
        hold_l_d    = hold_l_q;
        hold_r_d    = hold_r_q;
        hold_full_d = hold_full_q;
        shl_d       = shl_q;
        shr_d       = shr_q;
        underrun_d  = 1'b0;
        if (load_edge) begin
            if (hold_full_q) begin
                shl_d       = hold_l_q;
                shr_d       = hold_r_q;
                hold_full_d = 1'b0;
            end else begin
                shl_d      = '0;
                shr_d      = '0;
                underrun_d = 1'b1;
            end
        end
        if (accept) begin
            hold_l_d    = left_in;
            hold_r_d    = right_in;
            hold_full_d = 1'b1;
        end
    end

    // Choose the serial bit for the coming cycle. The word is read after any
    // transfer on this edge, so the left MSB goes out in the same cycle the
    // new pair lands. The right word changes only on the transfer edge, after
    // its LSB has already been registered.
    always_comb begin
        out_word    = (next_chan == LEFT) ? shl_d : shr_d;
        out_shifted = out_word << next_bit;
        sdata_d     = (next_bit < BITS_C) ? out_shifted[BITSIZE-1] : 1'b0;
    end

    // Buffer, shift-pair and serial-output registers
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            hold_l_q    <= '0;
            hold_r_q    <= '0;
            hold_full_q <= 1'b0;
            shl_q       <= '0;
            shr_q       <= '0;
            sdata_q     <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            hold_l_q    <= hold_l_d;
            hold_r_q    <= hold_r_d;
            hold_full_q <= hold_full_d;
            shl_q       <= shl_d;
            shr_q       <= shr_d;
            sdata_q     <= sdata_d;
            underrun_q  <= underrun_d;
        end
    end

    assign sample_ready = !hold_full_q;
    assign sdata        = sdata_q;
    assign underrun     = underrun_q;

endmodule

// File: tb/tb_i2s_tx.sv
// Testbench for i2s_tx. The main instance uses 24-bit samples in 24-bit
// slots. A second instance uses 24-bit samples in 32-bit slots to cover the
// zero padding and a mid-frame reset. The main instance is compared every
// cycle against a frame-level reference model. Serial frames are also
// reassembled and compared against the pairs that were offered.
module tb_i2s_tx;

    localparam int BITS  = 24;
    localparam int SLOT  = 24;
    localparam int FRAME = 2 * SLOT;

    logic            sclk = 1'b0;
    logic            rst  = 1'b1;
    logic [BITS-1:0] left_in = '0, right_in = '0;
    logic            sample_valid = 1'b0;
    logic            sample_ready, lrclk, sdata, frame_start, underrun;

    logic            rst32 = 1'b1;
    logic [BITS-1:0] left32 = '0, right32 = '0;
    logic            valid32 = 1'b0;
    logic            ready32, lrclk32, sdata32, fs32, ur32;

    int total = 0;
    int bad   = 0;

    always #5 sclk = ~sclk;

    i2s_tx #(.BITSIZE(BITS), .SLOT(SLOT)) dut (
        .sclk(sclk), .rst(rst), .left_in(left_in), .right_in(right_in),
        .sample_valid(sample_valid), .sample_ready(sample_ready), .lrclk(lrclk),
        .sdata(sdata), .frame_start(frame_start), .underrun(underrun)
    );

    i2s_tx #(.BITSIZE(BITS), .SLOT(32)) dut32 (
        .sclk(sclk), .rst(rst32), .left_in(left32), .right_in(right32),
        .sample_valid(valid32), .sample_ready(ready32), .lrclk(lrclk32),
        .sdata(sdata32), .frame_start(fs32), .underrun(ur32)
    );

    // Reference model for the main instance, at frame level. m_pos is the
    // position in the frame. A stored pair becomes the current frame when the
    // position goes 0 -> 1. Without a stored pair the frame is silent and
    // marked as an underrun.
    int              m_pos;
    bit              m_hold_full, m_ur;
    logic [BITS-1:0] m_hold_l, m_hold_r, m_cur_l, m_cur_r;

    always @(posedge sclk or posedge rst) begin
        if (rst) begin
            m_pos <= 0; m_hold_full <= 1'b0; m_ur <= 1'b0;
            m_cur_l <= '0; m_cur_r <= '0;
        end else begin
            if (m_pos == 0) begin
                m_cur_l <= m_hold_full ? m_hold_l : '0;
                m_cur_r <= m_hold_full ? m_hold_r : '0;
                m_ur    <= !m_hold_full;
            end
            if (m_pos == 0 && m_hold_full) begin
                m_hold_full <= 1'b0;
            end else if (sample_valid && !m_hold_full) begin
                m_hold_full <= 1'b1;
                m_hold_l    <= left_in;
                m_hold_r    <= right_in;
            end
            m_pos <= (m_pos + 1) % FRAME;
        end
    end

    // Serial bit that the I2S framing rules give for a frame position
    function automatic logic exp_bit(input int pos, input int slot,
                                     input logic [BITS-1:0] l, input logic [BITS-1:0] r);
        int d; int b; logic [BITS-1:0] w;
        d = (pos + 2 * slot - 1) % (2 * slot);
        b = d % slot;
        w = (d < slot) ? l : r;
        if (b < BITS) return w[BITS-1-b];
        return 1'b0;
    endfunction

    task automatic test_reset();
        rst = 1'b1; rst32 = 1'b1;
        repeat (3) @(negedge sclk);
        total++;
        if ({sample_ready, lrclk, sdata, frame_start, underrun} !== 5'b10000) begin
            bad++;
            $display("[TB] FAIL reset24 got=%b exp=10000",
                     {sample_ready, lrclk, sdata, frame_start, underrun});
        end
        total++;
        if ({ready32, lrclk32, sdata32, fs32, ur32} !== 5'b10000) begin
            bad++;
            $display("[TB] FAIL reset32 got=%b exp=10000", {ready32, lrclk32, sdata32, fs32, ur32});
        end
        rst = 1'b0;
    endtask

    task automatic test_idle_underrun();
        logic [4:0] exp5, got5;
        logic       prev_lr;
        int         toggles, urs;
        prev_lr = lrclk; toggles = 0; urs = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge sclk);
            exp5 = {1'b1, m_pos >= SLOT, 1'b0, m_pos == 1, m_pos == 1};
            got5 = {sample_ready, lrclk, sdata, frame_start, underrun};
            total++;
            if (got5 !== exp5) begin
                bad++;
                $display("[TB] FAIL idle_cycle pos=%0d got=%b exp=%b", m_pos, got5, exp5);
            end
            if (lrclk !== prev_lr) toggles++;
            prev_lr = lrclk;
            if (underrun === 1'b1) urs++;
        end
        total++;
        if (toggles != 4 || urs != 2) begin
            bad++;
            $display("[TB] FAIL idle_counts toggles=%0d underruns=%0d exp=4/2", toggles, urs);
        end
    endtask

    task automatic test_single_pair();
        logic [4:0]  exp5, got5;
        logic [47:0] cap;
        int          guard;
        guard = 0;
        while (m_pos != 10 && guard < 200) begin @(negedge sclk); guard++; end
        sample_valid = 1'b1; left_in = 24'hA5A5A5; right_in = 24'h5A5A5A;
        @(negedge sclk);
        sample_valid = 1'b0;
        guard = 0;
        while (m_pos != 1 && guard < 200) begin @(negedge sclk); guard++; end
        total++;
        if (guard >= 200) begin bad++; $display("[TB] FAIL single_wait got=timeout exp=pos1"); end
        cap = '0;
        for (int i = 0; i < FRAME; i++) begin
            if (i > 0) @(negedge sclk);
            exp5 = {!m_hold_full, m_pos >= SLOT, exp_bit(m_pos, SLOT, m_cur_l, m_cur_r),
                    m_pos == 1, (m_pos == 1) && m_ur};
            got5 = {sample_ready, lrclk, sdata, frame_start, underrun};
            total++;
            if (got5 !== exp5) begin
                bad++;
                $display("[TB] FAIL single_cycle pos=%0d got=%b exp=%b", m_pos, got5, exp5);
            end
            if (i == 0) begin
                total++;
                if ({frame_start, underrun} !== 2'b10) begin
                    bad++;
                    $display("[TB] FAIL single_start got=%b exp=10", {frame_start, underrun});
                end
            end
            cap = {cap[46:0], sdata};
        end
        total++;
        if (cap !== 48'hA5A5A5_5A5A5A) begin
            bad++;
            $display("[TB] FAIL single_frame got=%h exp=a5a5a55a5a5a", cap);
        end
    endtask

    task automatic test_back_to_back();
        logic [47:0] q[$];
        logic [47:0] cap, frame_exp;
        logic [4:0]  exp5, got5;
        bit          acc_pending, started;
        int          acc_count, nbits, guard;
        guard = 0;
        while (m_pos != 2 && guard < 200) begin @(negedge sclk); guard++; end
        sample_valid = 1'b1;
        left_in = 24'($urandom); right_in = 24'($urandom);
        acc_pending = (sample_ready === 1'b1);
        started = 1'b0; acc_count = 0; nbits = 0; cap = '0; frame_exp = '0;
        for (int i = 0; i < 6 * FRAME || acc_pending; i++) begin
            @(negedge sclk);
            if (m_pos == 1) begin
                total++;
                if (acc_count != 1) begin
                    bad++;
                    $display("[TB] FAIL b2b_accepts got=%0d exp=1", acc_count);
                end
                acc_count = 0;
                frame_exp = (q.size() > 0) ? q.pop_front() : '0;
                started = 1'b1; nbits = 0;
            end
            if (acc_pending) begin
                q.push_back({left_in, right_in});
                acc_count++;
                left_in = 24'($urandom); right_in = 24'($urandom);
            end
            exp5 = {!m_hold_full, m_pos >= SLOT, exp_bit(m_pos, SLOT, m_cur_l, m_cur_r),
                    m_pos == 1, (m_pos == 1) && m_ur};
            got5 = {sample_ready, lrclk, sdata, frame_start, underrun};
            total++;
            if (got5 !== exp5) begin
                bad++;
                $display("[TB] FAIL b2b_cycle pos=%0d got=%b exp=%b", m_pos, got5, exp5);
            end
            if (started) begin
                cap = {cap[46:0], sdata};
                nbits++;
                if (nbits == FRAME) begin
                    total++;
                    if (cap !== frame_exp) begin
                        bad++;
                        $display("[TB] FAIL b2b_frame got=%h exp=%h", cap, frame_exp);
                    end
                end
            end
            acc_pending = sample_valid && (sample_ready === 1'b1);
            if (i >= 6 * FRAME - 1 && !acc_pending) sample_valid = 1'b0;
            if (i >= 6 * FRAME - 1 && acc_pending) sample_valid = 1'b1;
        end
        sample_valid = 1'b0;
    endtask

    task automatic test_valid_on_load_edge();
        logic [BITS-1:0] rl, rr;
        logic [47:0]     cap;
        logic [4:0]      exp5, got5;
        int              guard;
        sample_valid = 1'b0;
        guard = 0;
        while (!(m_pos == 0 && !m_hold_full) && guard < 300) begin @(negedge sclk); guard++; end
        rl = 24'($urandom) | 24'h800000; rr = 24'($urandom) | 24'h000001;
        sample_valid = 1'b1; left_in = rl; right_in = rr;
        @(negedge sclk);
        sample_valid = 1'b0;
        total++;
        if ({frame_start, underrun, sample_ready} !== 3'b110) begin
            bad++;
            $display("[TB] FAIL edge_accept got=%b exp=110", {frame_start, underrun, sample_ready});
        end
        cap = '0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            if (i > 0) @(negedge sclk);
            exp5 = {!m_hold_full, m_pos >= SLOT, exp_bit(m_pos, SLOT, m_cur_l, m_cur_r),
                    m_pos == 1, (m_pos == 1) && m_ur};
            got5 = {sample_ready, lrclk, sdata, frame_start, underrun};
            total++;
            if (got5 !== exp5) begin
                bad++;
                $display("[TB] FAIL edge_cycle pos=%0d got=%b exp=%b", m_pos, got5, exp5);
            end
            cap = {cap[46:0], sdata};
            if (i == FRAME - 1) begin
                total++;
                if (cap !== 48'h0) begin
                    bad++;
                    $display("[TB] FAIL edge_silent got=%h exp=0", cap);
                end
            end
            if (i == FRAME) begin
                total++;
                if ({frame_start, underrun} !== 2'b10) begin
                    bad++;
                    $display("[TB] FAIL edge_next_start got=%b exp=10", {frame_start, underrun});
                end
            end
        end
        total++;
        if (cap !== {rl, rr}) begin
            bad++;
            $display("[TB] FAIL edge_next_frame got=%h exp=%h", cap, {rl, rr});
        end
    endtask

    task automatic test_slot32();
        int              pos, fr;
        bit              held, exp_ur, acc_pending, done;
        logic [BITS-1:0] hold_l, hold_r, cur_l, cur_r;
        logic [4:0]      exp5, got5;
        pos = 0; fr = 0; held = 0; exp_ur = 0; acc_pending = 0; done = 0;
        hold_l = '0; hold_r = '0; cur_l = '0; cur_r = '0;
        rst32 = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge sclk);
            pos = (pos + 1) % 64;
            if (pos == 1) begin
                fr++;
                cur_l = held ? hold_l : '0;
                cur_r = held ? hold_r : '0;
                exp_ur = !held;
                held = 1'b0;
            end
            if (acc_pending) begin
                held = 1'b1; hold_l = left32; hold_r = right32;
                valid32 = 1'b0; acc_pending = 1'b0;
            end
            exp5 = {!held, pos >= 32, exp_bit(pos, 32, cur_l, cur_r), pos == 1, (pos == 1) && exp_ur};
            got5 = {ready32, lrclk32, sdata32, fs32, ur32};
            total++;
            if (got5 !== exp5) begin
                bad++;
                $display("[TB] FAIL slot32_cycle frame=%0d pos=%0d got=%b exp=%b", fr, pos, got5, exp5);
            end
            if (pos == 4 && fr >= 1 && fr <= 3) begin
                valid32 = 1'b1;
                left32 = 24'($urandom) | 24'h004000; right32 = 24'($urandom);
                acc_pending = 1'b1;
            end
            if (fr == 3 && pos == 10) begin
                rst32 = 1'b1;
                #1;
                total++;
                if ({ready32, lrclk32, sdata32, fs32, ur32} !== 5'b10000) begin
                    bad++;
                    $display("[TB] FAIL slot32_reset got=%b exp=10000",
                             {ready32, lrclk32, sdata32, fs32, ur32});
                end
                done = 1'b1;
            end
        end
        total++;
        if (!done) begin bad++; $display("[TB] FAIL slot32_reach got=timeout exp=frame3"); end
        valid32 = 1'b0;
        repeat (2) @(negedge sclk);
        rst32 = 1'b0;
        pos = 0; held = 0; cur_l = '0; cur_r = '0; exp_ur = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge sclk);
            pos = (pos + 1) % 64;
            if (pos == 1) exp_ur = 1'b1;
            exp5 = {1'b1, pos >= 32, 1'b0, pos == 1, (pos == 1) && exp_ur};
            got5 = {ready32, lrclk32, sdata32, fs32, ur32};
            total++;
            if (got5 !== exp5) begin
                bad++;
                $display("[TB] FAIL slot32_after_reset pos=%0d got=%b exp=%b", pos, got5, exp5);
            end
        end
    endtask

    initial begin
        test_reset();
        test_idle_underrun();
        test_single_pair();
        test_back_to_back();
        test_valid_on_load_edge();
        test_slot32();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got=running exp=finished");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/i2s_tx.md
Name: i2s_tx

Overview:
- I2S master transmitter, the stage directly upstream of the I2S receiver. Clocked by the bit clock `sclk`.
- Generates the word clock (`lrclk`) and serialises stereo samples onto `sdata`, MSB first, with the standard one-bit delay after each `lrclk` edge.
- Samples arrive over a valid/ready handshake and are double-buffered so the next frame can be accepted while the current one shifts out.
- The outputs can drive an `i2s_rx` instance directly (loopback) or a codec DAC input.

Parameters:
- BITSIZE, 24, sample width per channel.
- SLOT, 24, bit clocks per channel half-frame. Must be >= BITSIZE; unused trailing bits are sent as 0. Set SLOT = BITSIZE when driving `i2s_rx`.

Ports:
- sclk  in  1  bit clock. Everything here is on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- left_in  in  BITSIZE  left sample, accepted with the handshake.
- right_in  in  BITSIZE  right sample, accepted with the handshake.
- sample_valid  in  1  producer has a stereo pair on left_in/right_in.
- sample_ready  out  1  holding buffer empty; a pair is accepted when valid & ready at a rising edge.
- lrclk  out  1  word clock: 0 = left half-frame, 1 = right half-frame.
- sdata  out  1  serial data.
- frame_start  out  1  one-cycle pulse in the cycle the frame counter equals 1 (left MSB on sdata).
- underrun  out  1  one-cycle pulse, same cycle as frame_start, when the frame had no buffered sample.

Behaviour:
- Frame counter `cnt`:
  - Counts 0..2*SLOT-1, incrementing every sclk, wrapping to 0.
  - Free-running; there is no enable.
- lrclk:
  - Registered; equals 0 while cnt < SLOT, 1 otherwise.
  - Period = 2*SLOT sclk, duty 50%.
- sdata:
  - Registered. For the cycle with counter value c, let d = (c-1) mod 2*SLOT.
  - Channel = left if d < SLOT, else right. b = d mod SLOT.
  - sdata = shift_chan[BITSIZE-1-b] if b < BITSIZE, else 0.
  - Consequence: the MSB appears one sclk after each lrclk edge. With SLOT = BITSIZE, the right-channel LSB appears in the cycle with c = 0 of the next frame.
- Buffers:
  - Holding pair (hold_l, hold_r, hold_full) and shift pair (shl, shr).
  - sample_ready = !hold_full, combinational from the flag.
  - Handshake accept: hold <= inputs, hold_full <= 1.
- Load event, on the rising edge where cnt goes 0 -> 1:
  - If hold_full: shl/shr <= hold, hold_full <= 0.
  - Else: shl/shr <= 0 and underrun pulses during the cycle with c = 1.
  - shr must not change before the c = 0 cycle completes, because the previous right LSB is still in flight.
- Simultaneous accept and load on the same edge:
  - If hold_full was 1, ready was 0, so no accept can occur.
  - If hold was empty: the input is accepted into hold, the current frame still underruns, and the new pair goes out in the next frame. There is no bypass path.
- Producer rule: sample_valid and the data must stay stable until accepted. The block does not check this.
- Reset (async assert, release synchronous to sclk):
  - cnt = 0, lrclk = 0, sdata = 0.
  - shl = shr = 0, hold_full = 0, so sample_ready = 1.
  - frame_start = 0, underrun = 0.
- Reset mid-frame: the frame is aborted and the held sample is discarded. The first frame after release sends zeros unless a pair is accepted before the first 0 -> 1 edge.
- Latency: a pair accepted while hold and shift are idle appears with its left MSB at the next c = 1 cycle. The worst case is 2*SLOT + 1 sclk.

Decomposition:
- Shared package i2s_pkg:
  - Default BITSIZE/SLOT constants.
  - Function computing counter width, clog2(2*SLOT).
  - LEFT = 0 / RIGHT = 1 lrclk encoding, shared with i2s_rx.
- One natural sub-module, i2s_frame_gen: counter plus lrclk, frame_start, and d/b decode, reusable by a future clock-master i2s_rx wrapper.
- The handshake buffer and serialiser stay in i2s_tx.

Test Plan:
- Reset, no samples: sample_ready = 1, underrun pulses every 48 cycles, sdata = 0, lrclk toggles every 24 sclk.
- Accept left 0xA5A5A5 / right 0x5A5A5A before the first 0 -> 1 edge:
  - sdata at c = 1..24 = 1010_0101..., c = 25..48 = 0101_1010...
  - frame_start at c = 1, no underrun.
- Loopback into i2s_rx (BITSIZE = SLOT = 24), pairs 0x123456/0xFEDCBA then 0x800001/0x7FFFFF every frame: rx left_chan/right_chan reproduce each pair one frame later, with no underrun.
- Hold valid continuously: exactly one accept per frame. sample_ready falls after the accept and rises after the load edge, and data is never skipped or duplicated.
- Assert valid exactly on the 0 -> 1 edge with hold empty: underrun pulses for that frame and the pair is transmitted in the following frame.
- SLOT = 32, BITSIZE = 24: bits c = 25..32 and 57..64 are 0, MSB still at c = 1 and c = 33. Assert rst at c = 10: outputs clear immediately and sample_ready = 1.
